// File: rtl/mcpu_pkg.sv
// Shared MCPU fetch-path types and default widths.
package mcpu_pkg;

    localparam int unsigned DefWordSize  = 8;
    localparam int unsigned DefAddrWidth = 8;
    localparam int unsigned CntWidth     = 16;

    typedef struct packed {
        logic [DefAddrWidth-1:0] pc;
        logic [DefWordSize-1:0]  word;
    } fetch_entry_t;

endpackage

// File: rtl/mcpu_fetch_unit_if.sv
// Fetch-stage bus: RAM instruction port, control inputs and decode handshake.
// Perf counter signals exist only when MCPU_FETCH_PERF_EN is defined.
interface mcpu_fetch_unit_if #(
    parameter int unsigned WORD_SIZE  = mcpu_pkg::DefWordSize,
    parameter int unsigned ADDR_WIDTH = mcpu_pkg::DefAddrWidth
);
    logic [ADDR_WIDTH-1:0] instraddr;
    logic [WORD_SIZE-1:0]  instrrd;
    logic                  halt;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  instr_valid;
    logic [WORD_SIZE-1:0]  instr_data;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_ready;
`ifdef MCPU_FETCH_PERF_EN
    logic [mcpu_pkg::CntWidth-1:0] fetch_count;
    logic [mcpu_pkg::CntWidth-1:0] flush_count;

    modport master (
        output instraddr, instr_valid, instr_data, instr_pc, fetch_count, flush_count,
        input  instrrd, halt, redirect, redirect_pc, instr_ready
    );
    modport slave (
        input  instraddr, instr_valid, instr_data, instr_pc, fetch_count, flush_count,
        output instrrd, halt, redirect, redirect_pc, instr_ready
    );
`else
    modport master (
        output instraddr, instr_valid, instr_data, instr_pc,
        input  instrrd, halt, redirect, redirect_pc, instr_ready
    );
    modport slave (
        input  instraddr, instr_valid, instr_data, instr_pc,
        output instrrd, halt, redirect, redirect_pc, instr_ready
    );
`endif
endinterface

// File: rtl/mcpu_fetch_fifo.sv
// Prefetch FIFO of fetch entries with push, pop, flush and occupancy count.
module mcpu_fetch_fifo
    import mcpu_pkg::*;
#(
    parameter  int unsigned Depth = 4,
    localparam int unsigned PtrW  = $clog2(Depth),
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  fetch_entry_t      entry_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output fetch_entry_t      head_o,
    output logic [CntW-1:0]   count_o
);

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push_i && !pop_i) count_d = count_q + CntW'(1);
            if (!push_i && pop_i) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
    end

    // Empty FIFO presents zeros rather than stale storage.
    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/mcpu_fetch_unit.sv
// MCPU instruction fetch/prefetch stage with redirect flush.
// Optional perf counters are built when MCPU_FETCH_PERF_EN is defined.
module mcpu_fetch_unit
    import mcpu_pkg::*;
#(
    parameter int unsigned           WORD_SIZE  = DefWordSize,
    parameter int unsigned           ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic                 clk,
    input logic                 reset,
    mcpu_fetch_unit_if.master   bus
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CntW-1:0]       count;
    logic                  full, push, pop, valid;
    fetch_entry_t          push_entry, head;

    assign full  = (count == CntW'(FIFO_DEPTH));
    assign push  = !bus.halt && !bus.redirect && !full;
    assign valid = (count != '0) && !bus.redirect;
    assign pop   = valid && bus.instr_ready;

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = pc_q;
        push_entry.word = bus.instrrd;
    end

    always_comb begin
        pc_d = pc_q;
        if (bus.redirect)  pc_d = bus.redirect_pc;
        else if (push)     pc_d = pc_q + ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    mcpu_fetch_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .flush_i (bus.redirect),
        .head_o  (head),
        .count_o (count)
    );

    assign bus.instraddr   = pc_q;
    assign bus.instr_valid = valid;
    assign bus.instr_data  = head.word;
    assign bus.instr_pc    = head.pc;

`ifdef MCPU_FETCH_PERF_EN
    logic [CntWidth-1:0] fetch_count_q, fetch_count_d;
    logic [CntWidth-1:0] flush_count_q, flush_count_d;
    logic [CntWidth:0]   flush_sum;

    always_comb begin
        fetch_count_d = fetch_count_q;
        flush_count_d = flush_count_q;
        flush_sum     = {1'b0, flush_count_q} + (CntWidth + 1)'(count);
        if (push && fetch_count_q != '1) fetch_count_d = fetch_count_q + CntWidth'(1);
        if (bus.redirect) flush_count_d = flush_sum[CntWidth] ? '1 : flush_sum[CntWidth-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign bus.fetch_count = fetch_count_q;
    assign bus.flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_mcpu_fetch_unit.sv
// Self-checking bench for mcpu_fetch_unit against a queue-based reference model.
module tb_mcpu_fetch_unit;

    localparam int unsigned Depth = 4;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] word;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mcpu_fetch_unit_if #(.WORD_SIZE(8), .ADDR_WIDTH(8)) bus ();

    logic [7:0] ram [256];
    assign bus.instrrd = ram[bus.instraddr];

    mcpu_fetch_unit #(
        .WORD_SIZE  (8),
        .ADDR_WIDTH (8),
        .FIFO_DEPTH (Depth),
        .RESET_PC   (8'h00)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ent_t       q[$];
    logic [7:0] m_pc;
    int         m_fetch, m_flush;
    int         checks = 0;
    int         failures = 0;

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic logic exp_valid();
        return (q.size() != 0) && !bus.redirect;
    endfunction

    function automatic logic [7:0] exp_data();
        return (q.size() != 0) ? q[0].word : 8'h00;
    endfunction

    function automatic logic [7:0] exp_pc();
        return (q.size() != 0) ? q[0].pc : 8'h00;
    endfunction

    task automatic set_in(input logic h, input logic r, input logic [7:0] rpc, input logic rdy);
        bus.halt        = h;
        bus.redirect    = r;
        bus.redirect_pc = rpc;
        bus.instr_ready = rdy;
    endtask

    task automatic model_reset();
        q.delete();
        m_pc    = 8'h00;
        m_fetch = 0;
        m_flush = 0;
    endtask

    // Apply one clock edge to the model using the currently driven inputs, then to the DUT.
    task automatic advance();
        int  sz;
        logic do_pop;
        sz     = q.size();
        do_pop = exp_valid() && bus.instr_ready;
        if (bus.redirect) begin
            m_flush = sat16(m_flush + sz);
            q.delete();
            m_pc = bus.redirect_pc;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (!bus.halt && sz < Depth) begin
                q.push_back('{pc: m_pc, word: ram[m_pc]});
                m_pc    = m_pc + 8'd1;
                m_fetch = sat16(m_fetch + 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        set_in(1'b0, 1'b0, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", bus.instr_valid);
        end
        checks++;
        if (bus.instraddr !== 8'h00 || bus.instr_data !== 8'h00 || bus.instr_pc !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got addr=%h data=%h pc=%h exp 00/00/00",
                     bus.instraddr, bus.instr_data, bus.instr_pc);
        end
`ifdef MCPU_FETCH_PERF_EN
        checks++;
        if (bus.fetch_count !== 16'd0 || bus.flush_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters got %0d/%0d exp 0/0", bus.fetch_count, bus.flush_count);
        end
`endif
        do_reset();
        advance();
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h00 || bus.instr_data !== 8'h11) begin
            failures++;
            $display("FAIL first_fetch got v=%b pc=%h d=%h exp 1/00/11",
                     bus.instr_valid, bus.instr_pc, bus.instr_data);
        end
        advance();
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h01 || bus.instr_data !== 8'h22) begin
            failures++;
            $display("FAIL second_fetch got v=%b pc=%h d=%h exp 1/01/22",
                     bus.instr_valid, bus.instr_pc, bus.instr_data);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) advance();
        checks++;
        if (bus.instraddr !== 8'h04 || bus.instr_pc !== 8'h00 || bus.instr_data !== 8'h11) begin
            failures++;
            $display("FAIL bp_hold got addr=%h pc=%h d=%h exp 04/00/11",
                     bus.instraddr, bus.instr_pc, bus.instr_data);
        end
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'(i)) begin
                failures++;
                $display("FAIL bp_release[%0d] got v=%b pc=%h exp 1/%h",
                         i, bus.instr_valid, bus.instr_pc, 8'(i));
            end
            advance();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) advance();
        set_in(1'b0, 1'b1, 8'h80, 1'b1);
        #1;
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_valid got=%b exp=0", bus.instr_valid);
        end
        advance();
        bus.redirect = 1'b0;
        #1;
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.instraddr !== 8'h80) begin
            failures++;
            $display("FAIL redir_after got v=%b addr=%h exp 0/80", bus.instr_valid, bus.instraddr);
        end
        advance();
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h80 || bus.instr_data !== 8'hA5) begin
            failures++;
            $display("FAIL redir_target got v=%b pc=%h d=%h exp 1/80/a5",
                     bus.instr_valid, bus.instr_pc, bus.instr_data);
        end
`ifdef MCPU_FETCH_PERF_EN
        checks++;
        if (bus.flush_count !== 16'd3) begin
            failures++;
            $display("FAIL redir_flush_count got=%0d exp=3", bus.flush_count);
        end
`endif
    endtask

    task automatic test_wrap();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'hFE;
        exp_seq[1] = 8'hFF;
        exp_seq[2] = 8'h00;
        exp_seq[3] = 8'h01;
        do_reset();
        set_in(1'b0, 1'b1, 8'hFE, 1'b1);
        advance();
        bus.redirect = 1'b0;
        advance();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp_seq[i]
                || bus.instr_data !== ram[exp_seq[i]]) begin
                failures++;
                $display("FAIL wrap[%0d] got v=%b pc=%h d=%h exp 1/%h/%h", i, bus.instr_valid,
                         bus.instr_pc, bus.instr_data, exp_seq[i], ram[exp_seq[i]]);
            end
            advance();
        end
    endtask

    task automatic test_halt();
        do_reset();
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        advance();
        advance();
        set_in(1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'(i)) begin
                failures++;
                $display("FAIL halt_drain[%0d] got v=%b pc=%h exp 1/%h",
                         i, bus.instr_valid, bus.instr_pc, 8'(i));
            end
            advance();
        end
        advance();
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.instraddr !== 8'h02) begin
            failures++;
            $display("FAIL halt_frozen got v=%b addr=%h exp 0/02", bus.instr_valid, bus.instraddr);
        end
        bus.halt = 1'b0;
        advance();
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 8'h02 || bus.instr_data !== ram[2]) begin
            failures++;
            $display("FAIL halt_resume got v=%b pc=%h d=%h exp 1/02/%h",
                     bus.instr_valid, bus.instr_pc, bus.instr_data, ram[2]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) advance();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.instraddr !== 8'h00 || bus.instr_data !== 8'h00) begin
            failures++;
            $display("FAIL async_reset got v=%b addr=%h d=%h exp 0/00/00",
                     bus.instr_valid, bus.instraddr, bus.instr_data);
        end
        @(posedge clk);
        #1;
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 500; n++) begin
            logic [7:0] rpc;
            rpc = (($urandom % 4) == 0) ? 8'(8'hFC + ($urandom % 4)) : 8'($urandom);
            set_in(($urandom % 4) == 0, ($urandom % 10) == 0, rpc, ($urandom % 3) != 0);
            #1;
            checks++;
            if (bus.instr_valid !== exp_valid() || bus.instr_data !== exp_data()
                || bus.instr_pc !== exp_pc() || bus.instraddr !== m_pc) begin
                failures++;
                $display("FAIL rand[%0d] got v=%b d=%h pc=%h addr=%h exp %b/%h/%h/%h", n,
                         bus.instr_valid, bus.instr_data, bus.instr_pc, bus.instraddr,
                         exp_valid(), exp_data(), exp_pc(), m_pc);
            end
`ifdef MCPU_FETCH_PERF_EN
            checks++;
            if (bus.fetch_count !== 16'(m_fetch) || bus.flush_count !== 16'(m_flush)) begin
                failures++;
                $display("FAIL rand_perf[%0d] got %0d/%0d exp %0d/%0d", n,
                         bus.fetch_count, bus.flush_count, m_fetch, m_flush);
            end
`endif
            advance();
        end
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        ram[8'h00] = 8'h11;
        ram[8'h01] = 8'h22;
        ram[8'h80] = 8'hA5;
        set_in(1'b0, 1'b0, 8'h00, 1'b1);
        model_reset();
        test_reset();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcpu_fetch_unit.md
# mcpu_fetch_unit

Instruction fetch/prefetch stage for the MCPU, sitting directly upstream of the decoder and driving the instruction port of MCPU_RAMController. Each cycle it presents a program counter on `instraddr` and captures the returned `instrrd` word into a small prefetch FIFO. The FIFO is drained by decode through a valid/ready handshake. Taken branches and jumps redirect the fetch program counter (PC) and flush the FIFO.

## Interface
- `WORD_SIZE`, 8, instruction word width; must match the RAM controller.
- `ADDR_WIDTH`, 8, instruction address width; must match the RAM controller.
- `FIFO_DEPTH`, 4, prefetch entries; power of two, ≥2.
- `RESET_PC`, 0, fetch address after reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `instraddr`  out  ADDR_WIDTH  fetch PC to the RAM controller instruction port.
- `instrrd`  in  WORD_SIZE  word at `instraddr`; combinational, same cycle.
- `halt`  in  1  suspends fetching while high; draining continues.
- `redirect`  in  1  one-cycle pulse: flush and restart at `redirect_pc`.
- `redirect_pc`  in  ADDR_WIDTH  new fetch address, sampled when `redirect`=1.
- `instr_valid`  out  1  head FIFO entry is available.
- `instr_data`  out  WORD_SIZE  head instruction word.
- `instr_pc`  out  ADDR_WIDTH  address the head word was fetched from.
- `instr_ready`  in  1  decode accepts the head entry.
- `fetch_count`  out  16  words pushed; present only under `MCPU_FETCH_PERF_EN`.
- `flush_count`  out  16  entries discarded by redirects; present only under `MCPU_FETCH_PERF_EN`.

## Operation
- **State.** Registered `pc`, FIFO storage, read/write pointers, occupancy `count` (0..FIFO_DEPTH).
- **Fetch address.** `instraddr` = `pc` at all times, whether or not a fetch occurs.
- **Push.** A push occurs when `!halt && !redirect && count<FIFO_DEPTH`.
  - Writes {`pc`, `instrrd`} into the FIFO.
  - `pc` ← `pc`+1, modulo 2^ADDR_WIDTH (0xFF wraps to 0x00).
- **Pop.** A pop occurs when `instr_valid && instr_ready`.
- **Valid.** `instr_valid` = `count!=0 && !redirect`.
- **Simultaneous push and pop.**
  - Both apply and `count` is unchanged.
  - When full, push is blocked even if a pop occurs in the same cycle; no full-bypass.
- **Redirect.** Highest priority.
  - The FIFO is cleared (`count`←0, pointers←0) and `pc`←`redirect_pc`.
  - No push occurs, and `instr_ready` is ignored.
  - Applies even while `halt` is high; fetching then stays suspended.
- **Halt.** Blocks push only. `pc` holds and the FIFO drains normally.
- **Reset values.**
  - `pc`=RESET_PC, so `instraddr`=RESET_PC.
  - FIFO empty, so `instr_valid`=0.
  - `instr_data`=0 and `instr_pc`=0 (empty-FIFO output is forced to zero).
  - Counters 0.
- **Reset mid-operation.** Reset asynchronously discards all FIFO contents and in-flight state.

## Timing
- Fetch latency: a word pushed at edge N is visible on `instr_*` after edge N, when the FIFO was empty. There is no bypass from `instrrd`.
- After reset deasserts, the first rising edge pushes RESET_PC. `instr_valid` rises after that edge.
- Redirect asserted before edge N: `pc`=`redirect_pc` after edge N. The target word is pushed at edge N+1 and valid after it.
- With continuous `instr_ready`=1 and no halt or redirect, throughput is one instruction per cycle.
- `instr_data`/`instr_pc` are stable while `instr_valid`=1 and `instr_ready`=0.

## Configuration
- **With `MCPU_FETCH_PERF_EN` defined:**
  - `fetch_count` increments on every push.
  - `flush_count` adds the pre-flush `count` on every redirect.
  - Both saturate at 0xFFFF and reset to 0.
- **Without `MCPU_FETCH_PERF_EN`:** both ports and their registers are absent, and behaviour is otherwise identical.

## Structure
- Shared package `mcpu_pkg` holds:
  - the `WORD_SIZE`/`ADDR_WIDTH` default constants;
  - the `fetch_entry_t` struct {pc, word};
  - the counter width constant (16).
- Sub-module `mcpu_fetch_fifo`:
  - a synchronous FIFO of `fetch_entry_t` with push, pop, flush and count;
  - pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
- The top level holds `pc`, the push/pop/redirect priority logic and the perf counters.

## Test plan
- **Reset.** Reset with RAM preloaded [0]=0x11, [1]=0x22 and `instr_ready`=1 → `instr_pc`/`instr_data` = 0/0x11 then 1/0x22 on consecutive cycles; one per cycle.
- **Backpressure.** `instr_ready`=0 for 10 cycles → `count` reaches 4, `instraddr` holds at 4, head stays 0/0x11. Releasing yields PCs 0,1,2,3,4 in order.
- **Redirect with 3 entries queued.** Pulse `redirect` with `redirect_pc`=0x80 ([0x80]=0xA5) → `instr_valid`=0 that cycle, next valid entry is 0x80/0xA5, and `flush_count` = +3 with the macro defined.
- **Wrap-around.** Redirect to 0xFE → entries at PCs 0xFE, 0xFF, 0x00, 0x01.
- **Halt.** `halt` held with 2 entries queued and `instr_ready`=1 → both drain, then `instr_valid`=0 and `instraddr` frozen. Deasserting `halt` resumes at the frozen address.
- **Async reset mid-stream.** Assert `reset` between edges while the FIFO is full → `instr_valid` drops immediately and `instraddr`=RESET_PC before the next edge.
